// File: rtl/usrt_pkg.sv
// rtl/usrt_pkg.sv - shared constants and types for the USRT receive path
package usrt_pkg;

    localparam int BAUD_W  = 14;
    localparam int FRAME_W = 11;

    localparam int START    = 0;
    localparam int DATA_LSB = 1;
    localparam int DATA_MSB = 8;
    localparam int PAR      = 9;
    localparam int STOP     = 10;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        EVEN     = 2'd1,
        ODD      = 2'd2,
        NONE_ALT = 2'd3
    } parity_mode_t;

endpackage

// File: rtl/usrt_rx_path_if.sv
// rtl/usrt_rx_path_if.sv - frame input and data register bus of the USRT receive path
interface usrt_rx_path_if;
    import usrt_pkg::*;

    logic [1:0]         i_Parity;
    logic               i_Frame_Valid;
    logic [FRAME_W-1:0] i_Frame;
    logic               i_Pop;
    logic [7:0]         o_Data;
    logic               o_Full;
    logic               o_Overrun;

    modport master (
        output i_Parity, i_Frame_Valid, i_Frame, i_Pop,
        input  o_Data, o_Full, o_Overrun
    );

    modport slave (
        input  i_Parity, i_Frame_Valid, i_Frame, i_Pop,
        output o_Data, o_Full, o_Overrun
    );

endinterface

// File: rtl/usrt_baudgen.sv
// rtl/usrt_baudgen.sv - baud clock generator, o_Bclk period is 2*i_Baud cycles
module usrt_baudgen
    import usrt_pkg::*;
(
    input  logic              i_Pclk,
    input  logic              i_Reset,
    input  logic [BAUD_W-1:0] i_Baud,
    output logic              o_Bclk
);

    localparam logic [BAUD_W-1:0] ONE = {{(BAUD_W-1){1'b0}}, 1'b1};

    logic [BAUD_W-1:0] cnt;

    always_ff @(posedge i_Pclk or negedge i_Reset) begin
        if (!i_Reset) begin
            cnt    <= '0;
            o_Bclk <= 1'b0;
        end else if (i_Baud == '0) begin
            cnt    <= '0;
            o_Bclk <= 1'b0;
        end else if (cnt == i_Baud - ONE) begin
            cnt    <= '0;
            o_Bclk <= ~o_Bclk;
        end else if (cnt >= i_Baud) begin
            // period shrank below the running count: restart without a toggle
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/usrt_rx_path.sv
// rtl/usrt_rx_path.sv - USRT receive path: baud clock, frame check and one-byte data register
module usrt_rx_path
    import usrt_pkg::*;
(
    input  logic              i_Pclk,
    input  logic              i_Reset,
    input  logic [BAUD_W-1:0] i_Baud,
    output logic              o_Bclk,
    usrt_rx_path_if.slave     bus
);

    logic         fv_q;
    logic         fv_rise;
    logic         push;
    logic [7:0]   push_byte;
    logic         frame_ok;
    logic         par_x;
    parity_mode_t mode;

    usrt_baudgen u_baudgen (
        .i_Pclk (i_Pclk),
        .i_Reset(i_Reset),
        .i_Baud (i_Baud),
        .o_Bclk (o_Bclk)
    );

    assign fv_rise = bus.i_Frame_Valid & ~fv_q;

    always_comb begin
        mode     = parity_mode_t'(bus.i_Parity);
        par_x    = ^bus.i_Frame[PAR:DATA_LSB];
        frame_ok = ~bus.i_Frame[START] & bus.i_Frame[STOP];
        case (mode)
            EVEN:    if (par_x)  frame_ok = 1'b0;
            ODD:     if (!par_x) frame_ok = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Reset) begin
        if (!i_Reset) begin
            fv_q      <= 1'b0;
            push      <= 1'b0;
            push_byte <= 8'h00;
        end else begin
            fv_q <= bus.i_Frame_Valid;
            push <= fv_rise & frame_ok;
            if (fv_rise)
                push_byte <= bus.i_Frame[DATA_MSB:DATA_LSB];
        end
    end

    // a push that coincides with a pop replaces the byte being read out
    always_ff @(posedge i_Pclk or negedge i_Reset) begin
        if (!i_Reset) begin
            bus.o_Data    <= 8'h00;
            bus.o_Full    <= 1'b0;
            bus.o_Overrun <= 1'b0;
        end else begin
            if (push && (!bus.o_Full || bus.i_Pop)) begin
                bus.o_Data <= push_byte;
                bus.o_Full <= 1'b1;
            end else if (bus.i_Pop) begin
                bus.o_Full <= 1'b0;
            end

            if (bus.i_Pop)
                bus.o_Overrun <= 1'b0;
            else if (push && bus.o_Full)
                bus.o_Overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usrt_rx_path.sv
// tb/tb_usrt_rx_path.sv - directed self-checking bench for usrt_rx_path
module tb_usrt_rx_path;
    import usrt_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BAUD_W-1:0] baud;
    logic              bclk;

    usrt_rx_path_if bus();

    usrt_rx_path dut (
        .i_Pclk (clk),
        .i_Reset(rst_n),
        .i_Baud (baud),
        .o_Bclk (bclk),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit        send;
        bit [1:0]  par;
        bit [10:0] frame;
        bit        pop;
        bit [7:0]  exp_data;
        bit        exp_full;
        bit        exp_ovr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] par, input logic [10:0] fr, input int hold);
        bus.i_Parity      = par;
        bus.i_Frame       = fr;
        bus.i_Frame_Valid = 1'b1;
        tick(hold);
        bus.i_Frame_Valid = 1'b0;
    endtask

    task automatic do_pop();
        bus.i_Pop = 1'b1;
        tick();
        bus.i_Pop = 1'b0;
    endtask

    task automatic check_reg(input string tag, input int d, input int f, input int o);
        check({tag, "_data"}, bus.o_Data, d);
        check({tag, "_full"}, bus.o_Full, f);
        check({tag, "_ovr"},  bus.o_Overrun, o);
    endtask

    initial begin
        int ones;
        int rises;
        int first_rise;
        logic prev;

        vecs[0]  = '{1'b0, 2'd0, 11'b00000000000, 1'b1, 8'h35, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 11'b11001101010, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 11'b00001101010, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 11'b11010111010, 1'b0, 8'h5D, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'd0, 11'b10101001010, 1'b0, 8'h5D, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 11'b00000000000, 1'b1, 8'h5D, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 11'b10101001011, 1'b0, 8'h5D, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 11'b10001101010, 1'b0, 8'h5D, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 11'b11001101010, 1'b0, 8'h35, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 11'b00000000000, 1'b1, 8'h35, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 11'b00000000000, 1'b1, 8'h35, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'd1, 11'b10001101010, 1'b0, 8'h35, 1'b1, 1'b0};

        baud              = 14'd5;
        bus.i_Parity      = 2'd0;
        bus.i_Frame       = '0;
        bus.i_Frame_Valid = 1'b0;
        bus.i_Pop         = 1'b0;

        tick(2);
        check_reg("reset", 0, 0, 0);
        check("reset_bclk", bclk, 0);

        // baud = 5: low for 5 cycles, then 10-cycle period at 50% duty
        rst_n = 1'b1;
        ones = 0; rises = 0; first_rise = 0; prev = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bclk) ones++;
            if (bclk && !prev) begin
                rises++;
                if (first_rise == 0) first_rise = k;
            end
            prev = bclk;
        end
        check("baud5_high_cycles", ones, 20);
        check("baud5_rises", rises, 4);
        check("baud5_first_rise", first_rise, 5);

        baud = 14'd0;
        tick();
        ones = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bclk) ones++;
        end
        check("baud0_held_low", ones, 0);

        // shrink the period below the running count: wrap without toggle
        baud = 14'd10;
        tick(7);
        baud = 14'd3;
        tick(3);
        check("shrink_no_toggle", bclk, 0);
        tick();
        check("shrink_then_toggle", bclk, 1);
        baud = 14'd5;

        // even frame 0x35: o_Full rises two cycles after the edge
        bus.i_Parity      = 2'd1;
        bus.i_Frame       = 11'b10001101010;
        bus.i_Frame_Valid = 1'b1;
        tick();
        bus.i_Frame_Valid = 1'b0;
        check("lat_full_cycle1", bus.o_Full, 0);
        tick();
        check("lat_full_cycle2", bus.o_Full, 1);
        check_reg("even35", 8'h35, 1, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].send) begin
                send(vecs[i].par, vecs[i].frame, 1);
                tick(2);
            end
            if (vecs[i].pop) begin
                do_pop();
                tick();
            end
            check_reg($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_full, vecs[i].exp_ovr);
        end

        // push and pop in the same cycle while full
        bus.i_Parity      = 2'd0;
        bus.i_Frame       = 11'b10101001010;
        bus.i_Frame_Valid = 1'b1;
        tick();
        bus.i_Frame_Valid = 1'b0;
        bus.i_Pop         = 1'b1;
        tick();
        bus.i_Pop         = 1'b0;
        tick();
        check_reg("push_pop", 8'hA5, 1, 0);
        do_pop();
        check("push_pop_drain", bus.o_Full, 0);

        // held-high valid must push only once
        send(2'd0, 11'b10010111010, 5);
        tick(2);
        check_reg("held_high", 8'h5D, 1, 0);
        do_pop();
        check_reg("held_high_pop", 8'h5D, 0, 0);

        // reset while a push is pending
        bus.i_Parity      = 2'd2;
        bus.i_Frame       = 11'b10010111010;
        bus.i_Frame_Valid = 1'b1;
        tick();
        rst_n             = 1'b0;
        bus.i_Frame_Valid = 1'b0;
        #1;
        check_reg("async_reset", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick(3);
        check_reg("pending_discarded", 0, 0, 0);

        send(2'd2, 11'b10010111010, 1);
        tick(2);
        check_reg("odd5D_after_reset", 8'h5D, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
